// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package memory_arbiter_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR,
        ACK
    } state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter, bundled in one interface.
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter/sequencer sharing one synchronous RAM between fetch (I)
// and load/store (D) ports, holding each port's read data between accesses.
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    memory_arbiter_if.slave  bus
);

    state_t            state;
    state_t            next_state;
    logic              last_grant;
    logic              grant;
    logic              any_req;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // On a tie the port that did not win last time gets the RAM.
    assign any_req = bus.i_req | bus.d_req;
    assign grant   = (bus.i_req && bus.d_req) ? ~last_grant
                                              : (bus.d_req ? PORT_D : PORT_I);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = (grant == PORT_D && bus.d_we) ? WR : RD_ISSUE;
                end
            end
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT:  next_state = ACK;
            WR:       next_state = ACK;
            ACK:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // last_grant doubles as the owner of the access in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            last_grant <= PORT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_grant <= grant;
                addr_q     <= (grant == PORT_D) ? bus.d_addr : bus.i_addr;
                if (grant == PORT_D) begin
                    wdata_q <= bus.d_wdata;
                end
            end
            if (state == RD_WAIT) begin
                if (last_grant == PORT_D) begin
                    d_rdata_q <= bus.mem_rdata;
                end else begin
                    i_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    // RAM strobes are gated by clr so nothing touches the RAM on a reset edge.
    assign bus.mem_read  = (state == RD_ISSUE) && !clr;
    assign bus.mem_write = (state == WR) && !clr;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_ack     = (state == ACK) && (last_grant == PORT_I);
    assign bus.d_ack     = (state == ACK) && (last_grant == PORT_D);
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: RAM model, cycle-level access model, and literal checks.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   check_en = 1'b0;
    int   i_ack_cnt = 0;

    memory_arbiter_if bus();

    memory_arbiter dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] initVal(input int a);
        return 32'hA500_0000 + a * 32'h0001_0003;
    endfunction

    // Physical RAM: registered read, garbage whenever read is low.
    logic [31:0] ram [0:511];
    logic [31:0] ram_q;
    bit          ram_init_done;
    assign bus.mem_rdata = ram_q;

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int a = 0; a < 512; a++) ram[a] <= initVal(a);
            ram_init_done <= 1'b1;
            ram_q <= 32'hBADB_AD00;
        end else begin
            if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_read) ram_q <= ram[bus.mem_addr];
            else              ram_q <= 32'hBADB_AD00;
        end
    end

    always @(negedge clk) if (bus.i_ack) i_ack_cnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Access model: each grant starts a timed transaction of fixed length.
    logic [31:0] m_mem [0:511];
    bit          m_init;
    bit          m_active, m_wr, m_owner, m_last;
    int          m_start;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_ir, m_dr;

    always @(negedge clk) begin
        logic e_rd, e_wr, e_ia, e_da, e_busy, g;
        int   p;
        if (!m_init) begin
            for (int a = 0; a < 512; a++) m_mem[a] = initVal(a);
            m_init = 1'b1;
        end
        e_rd = 0; e_wr = 0; e_ia = 0; e_da = 0; e_busy = 0;
        p = cyc - m_start;
        if (m_active) begin
            e_busy = 1;
            if (m_wr) begin
                e_wr = (p == 1);
                e_da = (p == 2);
            end else begin
                e_rd = (p == 1);
                e_ia = (p == 3) && !m_owner;
                e_da = (p == 3) && m_owner;
            end
        end
        if (clr) begin
            e_rd = 0;
            e_wr = 0;
        end
        if (check_en) begin
            checkOutput("busy",      32'(bus.busy),      32'(e_busy));
            checkOutput("mem_read",  32'(bus.mem_read),  32'(e_rd));
            checkOutput("mem_write", 32'(bus.mem_write), 32'(e_wr));
            checkOutput("i_ack",     32'(bus.i_ack),     32'(e_ia));
            checkOutput("d_ack",     32'(bus.d_ack),     32'(e_da));
            checkOutput("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
            checkOutput("i_rdata",   bus.i_rdata,        m_ir);
            checkOutput("d_rdata",   bus.d_rdata,        m_dr);
            checkOutput("rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
            if (e_wr) checkOutput("mem_wdata", bus.mem_wdata, m_wdata);
        end
        if (clr) begin
            m_active = 0; m_last = 0; m_owner = 0;
            m_addr = '0; m_wdata = '0; m_ir = '0; m_dr = '0;
        end else if (m_active) begin
            if (m_wr && p == 1) m_mem[m_addr] = m_wdata;
            if (!m_wr && p == 2) begin
                if (m_owner) m_dr = m_mem[m_addr];
                else         m_ir = m_mem[m_addr];
            end
            if ((m_wr && p == 2) || (!m_wr && p == 3)) m_active = 0;
        end else if (bus.i_req || bus.d_req) begin
            g = (bus.i_req && bus.d_req) ? !m_last : bus.d_req;
            m_active = 1;
            m_start  = cyc;
            m_owner  = g;
            m_last   = g;
            m_wr     = g && bus.d_we;
            m_addr   = g ? bus.d_addr : bus.i_addr;
            if (g) m_wdata = bus.d_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit ireq, input logic [8:0] iaddr, input bit dreq,
                                 input bit dwe, input logic [8:0] daddr, input logic [31:0] dwdata);
        bus.i_req   = ireq;
        bus.i_addr  = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
    endtask

    // Returns how many negedges after the call the ack appeared, or -1.
    task automatic waitAck(input bit port_d, input int budget, output int n);
        n = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (port_d ? bus.d_ack : bus.i_ack) begin
                n = k;
                return;
            end
        end
        total++;
        bad++;
        $display("[TB] FAIL ack_timeout: port_d=%0b got no ack, expected one within %0d cycles", port_d, budget);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected one before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, n2, cnt0, ia0, djob, ijob;
        logic [8:0]  d_addr_v, i_addr_v;
        logic [31:0] d_wdata_v;
        bit          d_we_v, hit;

        applyStimulus(0, '0, 0, 0, '0, '0);
        clr = 1'b1;
        repeat (3) tick();
        clr = 1'b0;
        check_en = 1'b1;
        $display("[TB] reset released");
        @(negedge clk);
        checkOutput("rst_busy",    32'(bus.busy),     32'd0);
        checkOutput("rst_i_rdata", bus.i_rdata,       32'd0);
        checkOutput("rst_d_rdata", bus.d_rdata,       32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);

        // D write 0x12345678 to 0x005, then I reads it back.
        tick();
        applyStimulus(0, '0, 1, 1, 9'h005, 32'h1234_5678);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t2_mem_write", 32'(bus.mem_write), 32'd1);
        checkOutput("t2_mem_addr",  32'(bus.mem_addr),  32'h005);
        @(negedge clk);
        checkOutput("t2_d_ack", 32'(bus.d_ack), 32'd1);
        tick();
        applyStimulus(1, 9'h005, 0, 0, '0, '0);
        waitAck(0, 10, n);
        checkOutput("t2_i_latency", 32'(n), 32'd3);
        checkOutput("t2_i_rdata", bus.i_rdata, 32'h1234_5678);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0);

        // Reset during RD_WAIT aborts the read with no ack.
        tick();
        applyStimulus(1, 9'h007, 0, 0, '0, '0);
        tick();
        tick();
        ia0 = i_ack_cnt;
        clr = 1'b1;
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick();
        clr = 1'b0;
        @(negedge clk);
        checkOutput("t3_busy",      32'(bus.busy),      32'd0);
        checkOutput("t3_i_rdata",   bus.i_rdata,        32'd0);
        checkOutput("t3_d_rdata",   bus.d_rdata,        32'd0);
        checkOutput("t3_mem_addr",  32'(bus.mem_addr),  32'd0);
        checkOutput("t3_mem_wdata", bus.mem_wdata,      32'd0);
        repeat (4) tick();
        checkOutput("t3_no_ack", 32'(i_ack_cnt - ia0), 32'd0);

        // Simultaneous requests right after reset: D first, I four cycles later.
        applyStimulus(1, 9'h005, 1, 0, 9'h010, '0);
        waitAck(1, 10, n);
        checkOutput("t4_d_latency", 32'(n), 32'd3);
        checkOutput("t4_d_rdata", bus.d_rdata, initVal(16));
        tick();
        applyStimulus(1, 9'h005, 0, 0, '0, '0);
        waitAck(0, 12, n2);
        checkOutput("t4_ack_gap", 32'(n2 + 1), 32'd4);
        checkOutput("t4_i_rdata", bus.i_rdata, 32'h1234_5678);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0);

        // Sustained contention: grants alternate D,I,D,I,D,I.
        djob = 0;
        ijob = 0;
        d_we_v = 1; d_addr_v = 9'h041; d_wdata_v = 32'h55AA_0000;
        i_addr_v = 9'h040;
        tick();
        applyStimulus(1, i_addr_v, 1, d_we_v, d_addr_v, d_wdata_v);
        for (int j = 0; j < 6; j++) begin
            hit = 0;
            for (int k = 0; k < 12 && !hit; k++) begin
                @(negedge clk);
                hit = bus.i_ack | bus.d_ack;
            end
            if (!hit) begin
                total++;
                bad++;
                $display("[TB] FAIL t5_ack_timeout: got no ack, expected access %0d", j);
            end
            checkOutput("t5_order", 32'(bus.d_ack), 32'((j % 2) == 0));
            tick();
            if (bus.d_ack === 1'b0 && (j % 2) == 0) begin end
            if ((j % 2) == 0) begin
                djob++;
                d_we_v    = djob[0] ? 1'b0 : 1'b1;
                d_addr_v  = djob[0] ? d_addr_v : 9'(9'h041 + djob);
                d_wdata_v = 32'h55AA_0000 + djob;
            end else begin
                ijob++;
                i_addr_v = 9'(9'h040 + ijob);
            end
            applyStimulus(1, i_addr_v, 1, d_we_v, d_addr_v, d_wdata_v);
        end
        applyStimulus(0, '0, 0, 0, '0, '0);
        repeat (6) tick();

        // Changing d_addr after grant must not redirect the write.
        applyStimulus(0, '0, 1, 1, 9'h020, 32'hCAFE_F00D);
        tick();
        applyStimulus(0, '0, 1, 1, 9'h021, 32'hCAFE_F00D);
        waitAck(1, 10, n);
        checkOutput("t6_latency", 32'(n), 32'd1);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0);
        @(negedge clk);
        checkOutput("t6_ram_020", ram[9'h020], 32'hCAFE_F00D);
        checkOutput("t6_ram_021", ram[9'h021], initVal(33));

        // Held i_req: back-to-back fetches, one ack each.
        tick();
        cnt0 = i_ack_cnt;
        applyStimulus(1, 9'h020, 0, 0, '0, '0);
        waitAck(0, 10, n);
        checkOutput("t7_first_latency", 32'(n), 32'd3);
        checkOutput("t7_i_rdata", bus.i_rdata, 32'hCAFE_F00D);
        waitAck(0, 10, n2);
        checkOutput("t7_ack_gap", 32'(n2 + 1), 32'd4);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0);
        repeat (5) tick();
        checkOutput("t7_pulses", 32'(i_ack_cnt - cnt0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and sequencer for the single-port synchronous RAM, sharing it between the instruction-fetch path and the load/store datapath. It sits between the CPU-side requesters and the RAM's `read` / `write` / `address_in` / `data_input` / `data_output` pins. It:
- serializes accesses with round-robin tie-breaking;
- sequences the RAM's one-cycle registered read;
- holds each port's read data stable, because the RAM outputs X whenever `read` is low.

## Interface
- `ADDR_W`, 9, word address width (512 words)
- `DATA_W`, 32, data width
- `clk`  in  1  single clock, rising edge
- `clr`  in  1  reset, synchronous, active-high
- `i_req`  in  1  fetch read request; `i_addr` stable while high
- `i_addr`  in  ADDR_W  fetch word address
- `i_ack`  out  1  one-cycle pulse: fetch complete, `i_rdata` valid
- `i_rdata`  out  DATA_W  fetch data; holds until the next fetch completes
- `d_req`  in  1  data request; `d_we`, `d_addr`, `d_wdata` stable while high
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data word address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle pulse: data access complete
- `d_rdata`  out  DATA_W  load data; holds until the next data read completes
- `mem_read`  out  1  to RAM `read`
- `mem_write`  out  1  to RAM `write`
- `mem_addr`  out  ADDR_W  to RAM `address_in`
- `mem_wdata`  out  DATA_W  to RAM `data_input`
- `mem_rdata`  in  DATA_W  from RAM `data_output`, valid the cycle after `mem_read`
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR, ACK.
- IDLE: pick a port from the live `i_req` / `d_req`.
  - Latch owner, address, write-enable and wdata.
  - Go to WR if owner is D with `d_we=1`; otherwise go to RD_ISSUE.
  - With no request, stay in IDLE.
- RD_ISSUE: `mem_read=1`, `mem_addr`=latched address. Go to RD_WAIT.
- RD_WAIT: `mem_read=0`. Capture `mem_rdata` into the owner's rdata register at the closing edge. Go to ACK.
- WR: `mem_write=1`, `mem_addr` and `mem_wdata` from the latched request. Go to ACK.
- ACK: pulse the owner's ack for exactly one cycle. Go to IDLE.
- Arbitration:
  - A single requester is always granted.
  - On a tie, grant the port not granted most recently.
  - `last_grant` resets to I, so D wins the first tie.
- Request fields are latched at grant. Requester changes after grant have no effect on the current access.
- A `req` still high in the cycle after ack is a new request.
- The non-owner's rdata and ack are never disturbed.
- `mem_read` and `mem_write` are never high together. Both are gated low combinationally while `clr=1`, so no RAM access occurs at a reset edge.
- `mem_addr` and `mem_wdata` hold the last latched values outside access cycles.
- Reset (any state, including mid-access):
  - state=IDLE; `last_grant`=I.
  - Outputs: `i_ack`=`d_ack`=0, `i_rdata`=`d_rdata`=0, `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0.
  - The aborted access gets no ack. The requester must re-request.

## Timing
- Cycle 0 = IDLE cycle in which `req` is sampled high.
- Read: RD_ISSUE in cycle 1, RD_WAIT in cycle 2, ack and valid rdata in cycle 3. Read latency is 3 cycles.
- Write: WR in cycle 1 (RAM updates at the end of cycle 1), ack in cycle 2. Write latency is 2 cycles.
- Earliest next grant is the cycle after ack. Back-to-back throughput is one read per 4 cycles, one write per 3 cycles.
- Under continuous contention the two ports alternate. Neither waits more than one foreign access.

## Structure
- Package `memory_arbiter_pkg` holds:
  - state enum;
  - port-id constants `PORT_I`, `PORT_D`;
  - default `ADDR_W` and `DATA_W`.
- Single module; no sub-module. The round-robin pick is a few lines of logic inside IDLE.

## Test plan
- Reset mid-read: `clr` asserted during RD_WAIT -> next cycle all outputs are 0, state IDLE, no ack at any point.
- D write then I read:
  - Stimulus: `d_req` with `d_we=1`, `d_addr=0x005`, `d_wdata=0x12345678`.
  - Required: `mem_write` in cycle 1 and `d_ack` in cycle 2.
  - Then `i_req` with `i_addr=0x005`. Required: `i_ack` in cycle 3 with `i_rdata=0x12345678`.
- Simultaneous requests after reset: `i_req` and `d_req` (read, 0x010) rise together -> D is granted first, I is served immediately after. `i_ack` occurs exactly 4 cycles after `d_ack`.
- Sustained contention over 6 accesses:
  - Grant order alternates D,I,D,I,...
  - `mem_read` and `mem_write` are never both high.
  - Idle `i_rdata` and `d_rdata` never show X.
- Field change after grant: `d_addr` changes from 0x020 to 0x021 in cycle 1 -> RAM is accessed at 0x020.
- Held request: `i_req` held high across ack -> second fetch is granted in the cycle after ack; each completed fetch produces exactly one `i_ack` pulse.
